// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions,
// exception codes and the exception handler entry address.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_LO  = 10;
  localparam int IM_HI  = 15;
  localparam int EXL_B  = 1;
  localparam int IE_B   = 0;
  localparam int BD_B   = 31;
  localparam int IP_LO  = 10;
  localparam int IP_HI  = 15;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  function automatic logic [31:0] pack_sr(
    input logic [5:0] im,
    input logic       exl,
    input logic       ie
  );
    logic [31:0] v;
    v = '0;
    v[IM_HI:IM_LO] = im;
    v[EXL_B] = exl;
    v[IE_B] = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(
    input logic       bd,
    input logic [5:0] ip,
    input logic [4:0] exc
  );
    logic [31:0] v;
    v = '0;
    v[BD_B] = bd;
    v[IP_HI:IP_LO] = ip;
    v[EXC_HI:EXC_LO] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId registers and the
// exception/interrupt request that flushes the pipeline.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_sr_wr;
  logic        w_epc_wr;
  logic [31:0] w_vic_pc;

  assign w_int_req = r_ie & ~r_exl & |(HWInt & r_im);
  assign w_exc_req = ~r_exl & (ExcCodeIn != 5'd0);
  assign Req       = ~reset & (w_int_req | w_exc_req);

  assign w_sr_wr  = en & (CP0Add == REG_SR);
  assign w_epc_wr = en & (CP0Add == REG_EPC);
  assign w_vic_pc = BDIn ? (VPC - 32'd4) : VPC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        r_exl <= 1'b1;
        r_bd  <= BDIn;
        r_exc <= w_int_req ? EXC_INT : ExcCodeIn;
        r_epc <= w_vic_pc;
      end else begin
        if (w_sr_wr) begin
          r_im  <= CP0In[IM_HI:IM_LO];
          r_exl <= CP0In[EXL_B];
          r_ie  <= CP0In[IE_B];
        end
        // ERET overrides an EXL value written in the same cycle
        if (EXLClr)
          r_exl <= 1'b0;
        if (w_epc_wr)
          r_epc <= CP0In;
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      REG_SR:    CP0Out = pack_sr(r_im, r_exl, r_ie);
      REG_CAUSE: CP0Out = pack_cause(r_bd, r_ip, r_exc);
      REG_EPC:   CP0Out = r_epc;
      REG_PRID:  CP0Out = PRID;
      default:   CP0Out = '0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
// Inputs change #1 after the rising edge; outputs are checked before the next one.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  cp0_unit #(.PRID(32'h0000_0007)) dut (
    .clk(clk), .reset(reset), .en(en),
    .CP0Add(CP0Add), .CP0In(CP0In), .VPC(VPC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr),
    .HWInt(HWInt), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    CP0Add = a;
    #1;
  endtask

  task automatic quiet();
    en = 0; EXLClr = 0; ExcCodeIn = 0; BDIn = 0; HWInt = 0;
    CP0In = 0; VPC = 0; CP0Add = 0;
  endtask

  task automatic test_reset();
    reset = 1; quiet(); ExcCodeIn = 5'd12;
    tick();
    vec++; if (Req !== 1'b0) begin $display("FAIL rst_req got %b exp 0", Req); err++; end
    ExcCodeIn = 0;
    rd(12); vec++; if (CP0Out !== 32'h0) begin $display("FAIL rst_sr got %h exp 0", CP0Out); err++; end
    rd(13); vec++; if (CP0Out !== 32'h0) begin $display("FAIL rst_cause got %h exp 0", CP0Out); err++; end
    rd(14); vec++; if (CP0Out !== 32'h0) begin $display("FAIL rst_epc got %h exp 0", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h0) begin $display("FAIL rst_epcout got %h exp 0", EPCOut); err++; end
    reset = 0;
    en = 1; CP0Add = 12; CP0In = 32'h2; tick();
    CP0Add = 14; CP0In = 32'h3010; tick();
    en = 0;
    rd(12); vec++; if (CP0Out !== 32'h2) begin $display("FAIL mid_sr got %h exp 2", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h3010) begin $display("FAIL mid_epc got %h exp 3010", EPCOut); err++; end
    HWInt = 6'h3f; reset = 1; tick();
    vec++; if (Req !== 1'b0) begin $display("FAIL mid_rst_req got %b exp 0", Req); err++; end
    HWInt = 0; reset = 0;
    rd(12); vec++; if (CP0Out !== 32'h0) begin $display("FAIL mid_rst_sr got %h exp 0", CP0Out); err++; end
    rd(13); vec++; if (CP0Out !== 32'h0) begin $display("FAIL mid_rst_cause got %h exp 0", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h0) begin $display("FAIL mid_rst_epc got %h exp 0", EPCOut); err++; end
  endtask

  task automatic test_exception();
    ExcCodeIn = 12; VPC = 32'h3020; BDIn = 0; #1;
    vec++; if (Req !== 1'b1) begin $display("FAIL ov_req got %b exp 1", Req); err++; end
    tick();
    ExcCodeIn = 5; #1;
    vec++; if (Req !== 1'b0) begin $display("FAIL exl_mask got %b exp 0", Req); err++; end
    ExcCodeIn = 0;
    rd(12); vec++; if (CP0Out !== 32'h2) begin $display("FAIL ov_sr got %h exp 2", CP0Out); err++; end
    rd(13); vec++; if (CP0Out !== 32'h30) begin $display("FAIL ov_cause got %h exp 30", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h3020) begin $display("FAIL ov_epc got %h exp 3020", EPCOut); err++; end
    EXLClr = 1; tick(); EXLClr = 0;
    rd(12); vec++; if (CP0Out !== 32'h0) begin $display("FAIL eret_sr got %h exp 0", CP0Out); err++; end
  endtask

  task automatic test_delay_slot();
    ExcCodeIn = 10; VPC = 32'h3024; BDIn = 1; #1;
    vec++; if (Req !== 1'b1) begin $display("FAIL ri_req got %b exp 1", Req); err++; end
    tick(); quiet();
    vec++; if (EPCOut !== 32'h3020) begin $display("FAIL bd_epc got %h exp 3020", EPCOut); err++; end
    rd(13); vec++; if (CP0Out !== 32'h8000_0028) begin $display("FAIL bd_cause got %h exp 80000028", CP0Out); err++; end
    EXLClr = 1; tick(); EXLClr = 0;
    ExcCodeIn = 4; VPC = 32'h0; BDIn = 1; tick(); quiet();
    vec++; if (EPCOut !== 32'hFFFF_FFFC) begin $display("FAIL bd_wrap got %h exp fffffffc", EPCOut); err++; end
    EXLClr = 1; tick(); EXLClr = 0;
  endtask

  task automatic test_int_priority();
    en = 1; CP0Add = 12; CP0In = 32'h0000_0401; tick(); en = 0;
    HWInt = 6'b000001; ExcCodeIn = 4; VPC = 32'h3040; #1;
    vec++; if (Req !== 1'b1) begin $display("FAIL int_req got %b exp 1", Req); err++; end
    tick();
    rd(13); vec++; if (CP0Out !== 32'h0000_0400) begin $display("FAIL int_cause got %h exp 400", CP0Out); err++; end
    rd(12); vec++; if (CP0Out !== 32'h0000_0403) begin $display("FAIL int_sr got %h exp 403", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h3040) begin $display("FAIL int_epc got %h exp 3040", EPCOut); err++; end
    vec++; if (Req !== 1'b0) begin $display("FAIL int_exl_mask got %b exp 0", Req); err++; end
    ExcCodeIn = 0; EXLClr = 1; #1;
    vec++; if (Req !== 1'b0) begin $display("FAIL eret_cycle_req got %b exp 0", Req); err++; end
    tick(); EXLClr = 0; #1;
    vec++; if (Req !== 1'b1) begin $display("FAIL eret_pending got %b exp 1", Req); err++; end
    HWInt = 0; #1;
    vec++; if (Req !== 1'b0) begin $display("FAIL int_drop got %b exp 0", Req); err++; end
    en = 1; CP0Add = 12; CP0In = 32'h0000_0400; tick(); en = 0;
    HWInt = 6'b000001; ExcCodeIn = 4; VPC = 32'h3044; #1;
    vec++; if (Req !== 1'b1) begin $display("FAIL ie0_req got %b exp 1", Req); err++; end
    tick();
    rd(13); vec++; if (CP0Out !== 32'h0000_0410) begin $display("FAIL ie0_cause got %h exp 410", CP0Out); err++; end
    quiet(); EXLClr = 1; tick(); EXLClr = 0;
  endtask

  task automatic test_mtc0();
    en = 1; CP0Add = 14; CP0In = 32'h3100; #1;
    vec++; if (EPCOut !== 32'h3044) begin $display("FAIL epc_pre got %h exp 3044", EPCOut); err++; end
    tick(); en = 0;
    vec++; if (EPCOut !== 32'h3100) begin $display("FAIL epc_wr got %h exp 3100", EPCOut); err++; end
    en = 1; CP0Add = 14; CP0In = 32'h3200; ExcCodeIn = 12; VPC = 32'h3050; BDIn = 0;
    tick(); quiet();
    vec++; if (EPCOut !== 32'h3050) begin $display("FAIL epc_drop got %h exp 3050", EPCOut); err++; end
    rd(12); vec++; if (CP0Out !== 32'h0000_0402) begin $display("FAIL req_sr got %h exp 402", CP0Out); err++; end
    en = 1; CP0Add = 12; CP0In = 32'h0000_8403; EXLClr = 1; tick(); quiet();
    rd(12); vec++; if (CP0Out !== 32'h0000_8401) begin $display("FAIL sr_eret got %h exp 8401", CP0Out); err++; end
    en = 1; CP0Add = 12; CP0In = 32'hFFFF_FFFF; tick(); en = 0;
    rd(12); vec++; if (CP0Out !== 32'h0000_FC03) begin $display("FAIL sr_mask got %h exp fc03", CP0Out); err++; end
    en = 1; CP0Add = 12; CP0In = 32'h0; tick(); en = 0;
    rd(12); vec++; if (CP0Out !== 32'h0) begin $display("FAIL sr_clr got %h exp 0", CP0Out); err++; end
  endtask

  task automatic test_read_mux();
    rd(15); vec++; if (CP0Out !== 32'h0000_0007) begin $display("FAIL prid got %h exp 7", CP0Out); err++; end
    rd(3); vec++; if (CP0Out !== 32'h0) begin $display("FAIL unk_rd got %h exp 0", CP0Out); err++; end
    en = 1; CP0Add = 13; CP0In = 32'hFFFF_FFFF; HWInt = 6'b101010; tick();
    CP0Add = 3; CP0In = 32'h1234_5677; tick(); en = 0;
    rd(13); vec++; if (CP0Out !== 32'h0000_A830) begin $display("FAIL cause_wr got %h exp a830", CP0Out); err++; end
    rd(12); vec++; if (CP0Out !== 32'h0) begin $display("FAIL unk_wr_sr got %h exp 0", CP0Out); err++; end
    vec++; if (EPCOut !== 32'h3050) begin $display("FAIL unk_wr_epc got %h exp 3050", EPCOut); err++; end
    HWInt = 0; tick();
    rd(13); vec++; if (CP0Out !== 32'h0000_0030) begin $display("FAIL ip_track got %h exp 30", CP0Out); err++; end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_delay_slot();
    test_int_priority();
    test_mtc0();
    test_read_mux();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the five-stage MIPS pipeline. It sits at the M stage and holds the SR, Cause, EPC and PRId registers. It combines the exception code, branch-delay flag, MTC0 and ERET controls carried down the pipeline with the six external hardware interrupt lines, and raises `Req`. `Req` flushes every pipeline register, and the flushed E register reloads its PC8 from the handler address.

## Interface
Parameters:
- `PRID`, default 32'h0000_0007: read-only processor ID returned for register 15.

Ports:
- `clk` in 1: clock, all state updates on its rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `en` in 1: MTC0 write enable (M-stage instruction is MTC0).
- `CP0Add` in 5: register number for MTC0 write and MFC0 read.
- `CP0In` in 32: MTC0 write data (forwarded rt value).
- `VPC` in 32: PC of the instruction currently in M (victim PC).
- `BDIn` in 1: M instruction sits in a branch delay slot.
- `ExcCodeIn` in 5: exception code of the M instruction; 0 means none.
- `EXLClr` in 1: ERET is in M.
- `HWInt` in 6: external interrupt lines, level-sensitive.
- `CP0Out` out 32: MFC0 read data.
- `EPCOut` out 32: current EPC, used as the ERET target.
- `Req` out 1: take exception/interrupt this cycle.

## Operation
- SR, register 12:
  - IM = bits [15:10], EXL = bit 1, IE = bit 0.
  - All other bits read 0 and ignore writes.
- Cause, register 13:
  - BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2].
  - All other bits read 0.
  - Not writable by MTC0.
- EPC, register 14: 32-bit, writable by MTC0.
- PRId, register 15: constant `PRID`.
- Unknown register numbers read 0; writes to them are ignored.
- Interrupt condition: `IntReq = IE & ~EXL & |(HWInt & IM)`.
- Exception condition: `ExcReq = ~EXL & (ExcCodeIn != 0)`.
- `Req = ~reset & (IntReq | ExcReq)`, combinational.
- Interrupts take priority over exceptions.
- When `Req` is high, on the clock edge:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= 0 if IntReq, else ExcCodeIn.
  - EPC <= BDIn ? VPC - 4 : VPC, 32-bit wraparound, low two bits kept as given.
- When `Req` is low:
  - If `EXLClr`: EXL <= 0.
  - If `en`: the write to SR or EPC commits. An SR write may also change EXL.
  - If both `en` (to SR) and `EXLClr`: EXL <= 0 takes precedence; IM and IE still take the written value.
- Simultaneous `Req` and `en`: the write is dropped, because the M instruction is being cancelled.
- Simultaneous `Req` and `EXLClr`: cannot occur, since Req requires EXL = 0. If it is forced anyway, the Req update wins.
- IP <= HWInt every cycle, regardless of EXL, IE or Req.
- `CP0Out` is a combinational mux on `CP0Add` over the current, pre-edge register values.
- `EPCOut` is the current EPC register; an MTC0 to EPC becomes visible the next cycle.

## Timing
- `Req`, `CP0Out` and `EPCOut` are combinational: zero-cycle latency from inputs and state.
- All register updates have a one-edge latency.
- Reset, while `reset` is high at the edge:
  - SR = 0, Cause = 0, EPC = 0.
  - `Req` = 0, `CP0Out` = 0 for registers 12–14, `EPCOut` = 0.
- Reset during handler execution (EXL = 1) clears EXL. No EPC is saved.
- After an exception, EXL = 1 masks all further `Req` until ERET or an MTC0 that clears EXL.
- A pending interrupt therefore fires in the first cycle after EXL falls, if IE and IM still allow it.
- Interrupt lines are not latched: an interrupt that deasserts before it is unmasked is lost.

## Structure
- Shared package `cp0_pkg` holds:
  - Register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - Field bit positions for IM, EXL, IE, BD, IP and ExcCode.
  - ExcCode constants: Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12.
  - Handler entry address 32'h0000_4180.
- The EPC-select and read mux is simple. The module is a single module with no sub-module.

## Test plan
- Reset mid-handler:
  - Set EXL = 1, EPC = 32'h3010, assert `reset` for one cycle.
  - Expect SR = 0, Cause = 0, EPC = 0, `Req` = 0.
- Exception not in a delay slot:
  - `ExcCodeIn` = 12 (Ov), `VPC` = 32'h3020, `BDIn` = 0, EXL = 0.
  - Expect `Req` = 1 the same cycle.
  - Next cycle: EXL = 1, Cause = 32'h0000_0030, EPC = 32'h3020.
- Delay-slot exception:
  - `ExcCodeIn` = 10, `VPC` = 32'h3024, `BDIn` = 1.
  - Expect EPC = 32'h3020 and Cause = 32'h8000_0028.
- Interrupt priority and masking:
  - SR = 32'h0000_0401, `HWInt` = 6'b000001, `ExcCodeIn` = 4.
  - Expect `Req` = 1 with ExcCode = 0.
  - Repeat with IE = 0: expect `Req` = 1 with ExcCode = 4.
  - With EXL = 1: expect `Req` = 0.
- MTC0 and ERET interaction:
  - `en` = 1, `CP0Add` = 14, `CP0In` = 32'h3100, Req = 0.
  - Expect `EPCOut` = 32'h3100 on the next cycle.
  - Same write while `Req` = 1: expect EPC to take the saved victim PC instead.
  - `EXLClr` with EXL = 1: expect EXL = 0, and a pending unmasked interrupt raises `Req` the next cycle.
- Read mux:
  - `CP0Add` = 15: `CP0Out` = 32'h0000_0007.
  - `CP0Add` = 3: `CP0Out` = 0.
  - Write to Cause ignored: Cause unchanged except IP tracking `HWInt`.
